// File: rtl/lns_accumulator_pkg.sv
// Shared constants and encodings for the LNS frame accumulator and its log-domain adder.
package lns_accumulator_pkg;

    localparam int WBITS    = 16;
    localparam int FRACBITS = 8;
    localparam int CNTW     = 8;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // A zero value always carries this magnitude and sign.
    localparam logic [WBITS-1:0] ZERO_MAG  = {WBITS{1'b0}};
    localparam logic             ZERO_SIGN = SIGN_POS;

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

    // 2.0 in a fraction field one bit wider than FRACBITS.
    localparam logic [FRACBITS+1:0] LIN_ONE = {1'b1, {(FRACBITS+1){1'b0}}};

endpackage

// File: rtl/lns_accumulator_log_adder.sv
// Combinational LNS adder: max(a,b) +/- 2^-|a-b|, with 2^-x approximated
// piecewise-linearly between integer powers of two and truncated.
module lns_accumulator_log_adder
    import lns_accumulator_pkg::*;
(
    input  logic [WBITS-1:0] a,
    input  logic             Sa,
    input  logic [WBITS-1:0] b,
    input  logic             Sb,
    output logic [WBITS-1:0] result,
    output logic             resultSign
);

    localparam int IBITS = WBITS + 1 - FRACBITS;

    logic [WBITS:0]      diff_s;
    logic [WBITS:0]      dist_s;
    logic                a_big_s;
    logic [WBITS-1:0]    big_s;
    logic [FRACBITS+1:0] lin_s;
    logic [FRACBITS+1:0] corr_s;
    logic [IBITS-1:0]    shamt_s;

    // Pick the dominant operand and form the correction term from the distance.
    always_comb begin
        diff_s  = {a[WBITS-1], a} - {b[WBITS-1], b};
        a_big_s = ~diff_s[WBITS];
        if (a_big_s) begin
            dist_s     = diff_s;
            big_s      = a;
            resultSign = Sa;
        end else begin
            dist_s     = {(WBITS+1){1'b0}} - diff_s;
            big_s      = b;
            resultSign = Sb;
        end
        lin_s   = LIN_ONE - {2'b00, dist_s[FRACBITS-1:0]};
        shamt_s = dist_s[WBITS:FRACBITS] + {{(IBITS-1){1'b0}}, 1'b1};
        corr_s  = lin_s >> shamt_s;
        if (Sa == Sb) begin
            result = big_s + {{(WBITS-FRACBITS-2){1'b0}}, corr_s};
        end else begin
            result = big_s - {{(WBITS-FRACBITS-2){1'b0}}, corr_s};
        end
    end

endmodule

// File: rtl/lns_accumulator.sv
// Framed streaming LNS accumulator: folds each accepted beat into a running
// sign/log-magnitude sum and presents one registered result per frame.
module lns_accumulator
    import lns_accumulator_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WBITS-1:0] in_mag,
    input  logic             in_sign,
    input  logic             in_zero,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WBITS-1:0] out_mag,
    output logic             out_sign,
    output logic             out_zero,
    output logic [CNTW-1:0]  out_count
);

    state_t           state_r;
    logic             first_r;
    logic             accept_s;

    logic             op_valid_r;
    logic [WBITS-1:0] op_mag_r;
    logic             op_sign_r;
    logic             op_zero_r;
    logic             op_last_r;
    logic             op_first_r;

    logic [WBITS-1:0] acc_mag_r;
    logic             acc_sign_r;
    logic             acc_zero_r;
    logic [CNTW-1:0]  count_r;

    logic [WBITS-1:0] add_mag_s;
    logic             add_sign_s;
    logic [WBITS-1:0] nxt_mag_s;
    logic             nxt_sign_s;
    logic             nxt_zero_s;
    logic [CNTW-1:0]  nxt_count_s;
    logic [CNTW-1:0]  count_inc_s;

    assign accept_s = in_valid & in_ready;

    lns_accumulator_log_adder log_adder (
        .a          (acc_mag_r),
        .Sa         (acc_sign_r),
        .b          (op_mag_r),
        .Sb         (op_sign_r),
        .result     (add_mag_s),
        .resultSign (add_sign_s)
    );

    // Frame sequencing with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_ACCUM;
            first_r   <= 1'b1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s) begin
                        first_r <= 1'b0;
                    end
                    if (accept_s && in_last) begin
                        state_r  <= ST_FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_r   <= ST_OUT;
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_r   <= ST_ACCUM;
                        first_r   <= 1'b1;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_ACCUM;
                    first_r   <= 1'b1;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_r <= 1'b0;
            op_mag_r   <= ZERO_MAG;
            op_sign_r  <= ZERO_SIGN;
            op_zero_r  <= 1'b0;
            op_last_r  <= 1'b0;
            op_first_r <= 1'b0;
        end else begin
            op_valid_r <= accept_s;
            if (accept_s) begin
                op_mag_r   <= in_mag;
                op_sign_r  <= in_sign;
                op_zero_r  <= in_zero;
                op_last_r  <= in_last;
                op_first_r <= first_r;
            end
        end
    end

    // Next accumulator value; exact cancellation is caught here since the adder cannot express it.
    always_comb begin
        count_inc_s = (count_r == CNT_MAX) ? CNT_MAX : count_r + CNT_ONE;
        if (op_valid_r) begin
            if (op_first_r) begin
                if (op_zero_r) begin
                    nxt_mag_s   = ZERO_MAG;
                    nxt_sign_s  = ZERO_SIGN;
                    nxt_zero_s  = 1'b1;
                    nxt_count_s = CNT_ZERO;
                end else begin
                    nxt_mag_s   = op_mag_r;
                    nxt_sign_s  = op_sign_r;
                    nxt_zero_s  = 1'b0;
                    nxt_count_s = CNT_ONE;
                end
            end else if (op_zero_r) begin
                nxt_mag_s   = acc_mag_r;
                nxt_sign_s  = acc_sign_r;
                nxt_zero_s  = acc_zero_r;
                nxt_count_s = count_r;
            end else if (acc_zero_r) begin
                nxt_mag_s   = op_mag_r;
                nxt_sign_s  = op_sign_r;
                nxt_zero_s  = 1'b0;
                nxt_count_s = count_inc_s;
            end else if ((op_mag_r == acc_mag_r) && (op_sign_r != acc_sign_r)) begin
                nxt_mag_s   = ZERO_MAG;
                nxt_sign_s  = ZERO_SIGN;
                nxt_zero_s  = 1'b1;
                nxt_count_s = count_inc_s;
            end else begin
                nxt_mag_s   = add_mag_s;
                nxt_sign_s  = add_sign_s;
                nxt_zero_s  = 1'b0;
                nxt_count_s = count_inc_s;
            end
        end else begin
            nxt_mag_s   = acc_mag_r;
            nxt_sign_s  = acc_sign_r;
            nxt_zero_s  = acc_zero_r;
            nxt_count_s = count_r;
        end
    end

    // Accumulator state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_mag_r  <= ZERO_MAG;
            acc_sign_r <= ZERO_SIGN;
            acc_zero_r <= 1'b0;
            count_r    <= CNT_ZERO;
        end else begin
            acc_mag_r  <= nxt_mag_s;
            acc_sign_r <= nxt_sign_s;
            acc_zero_r <= nxt_zero_s;
            count_r    <= nxt_count_s;
        end
    end

    // Result registers load only when the last beat is applied, so they hold through any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_mag   <= ZERO_MAG;
            out_sign  <= ZERO_SIGN;
            out_zero  <= 1'b0;
            out_count <= CNT_ZERO;
        end else if (op_valid_r && op_last_r) begin
            out_mag   <= nxt_mag_s;
            out_sign  <= nxt_sign_s;
            out_zero  <= nxt_zero_s;
            out_count <= nxt_count_s;
        end
    end

endmodule

// File: tb/tb_lns_accumulator.sv
// Self-checking bench for lns_accumulator: directed frames from the test plan
// plus randomized frames against a frame-level reference model.
module tb_lns_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mag;
    logic        in_sign;
    logic        in_zero;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mag;
    logic        out_sign;
    logic        out_zero;
    logic [7:0]  out_count;

    int checks = 0;
    int errors = 0;

    // reference model of the running frame sum
    logic [15:0] m_mag;
    logic        m_sign;
    logic        m_zero;
    logic        m_first;
    int          m_nz;

    always #5 clk = ~clk;

    lns_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden log-domain sum: larger value +/- (1 - f/2) * 2^-i * 256, truncated,
    // where i.f is the distance between the two log magnitudes.
    task automatic ref_log_add(input logic [15:0] a, input logic sa, input logic [15:0] b,
                               input logic sb, output logic [15:0] res, output logic rs);
        int  ai, bi, big, d, ip, fr, corr;
        real v;
        ai = int'($signed(a));
        bi = int'($signed(b));
        big = (ai >= bi) ? ai : bi;
        rs  = (ai >= bi) ? sa : sb;
        d   = (ai >= bi) ? (ai - bi) : (bi - ai);
        ip  = d / 256;
        fr  = d % 256;
        v    = (1.0 - real'(fr) / 512.0) * 256.0 / (2.0 ** real'(ip));
        corr = int'($floor(v));
        res  = (sa == sb) ? 16'(big + corr) : 16'(big - corr);
    endtask

    task automatic model_new_frame();
        m_mag = 16'h0000; m_sign = 1'b0; m_zero = 1'b1; m_first = 1'b1; m_nz = 0;
    endtask

    task automatic model_apply(input logic [15:0] mag, input logic sgn, input logic zr);
        logic [15:0] r;
        logic        rs;
        m_first = 1'b0;
        if (!zr) begin
            m_nz++;
            if (m_zero) begin
                m_mag = mag; m_sign = sgn; m_zero = 1'b0;
            end else if (mag == m_mag && sgn != m_sign) begin
                m_mag = 16'h0000; m_sign = 1'b0; m_zero = 1'b1;
            end else begin
                ref_log_add(m_mag, m_sign, mag, sgn, r, rs);
                m_mag = r; m_sign = rs;
            end
        end
    endtask

    task automatic beat(input logic [15:0] mag, input logic sgn, input logic zr, input logic lst);
        in_valid = 1'b1; in_mag = mag; in_sign = sgn; in_zero = zr; in_last = lst;
        chk("in_ready_beat", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_mag = 16'($urandom); in_sign = 1'($urandom);
        model_apply(mag, sgn, zr);
    endtask

    task automatic expect_result(input string tag, input int stall);
        int lat;
        int exp_cnt;
        lat = 0;
        exp_cnt = (m_nz > 255) ? 255 : m_nz;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd1);
        chk({tag, "_mag"},   32'(out_mag),   32'(m_mag));
        chk({tag, "_sign"},  32'(out_sign),  32'(m_sign));
        chk({tag, "_zero"},  32'(out_zero),  32'(m_zero));
        chk({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
        chk({tag, "_in_ready_out"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_mag"},   32'(out_mag),   32'(m_mag));
            chk({tag, "_stall_count"}, 32'(out_count), 32'(exp_cnt));
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        model_new_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          nb;
        int          gap;
        logic [15:0] mg;
        logic        sg;
        logic        zr;

        rst = 1'b1; in_valid = 1'b0; in_mag = 16'h0000; in_sign = 1'b0;
        in_zero = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_new_frame();
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mag",   32'(out_mag),   32'd0);
        chk("rst_out_sign",  32'(out_sign),  32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        tick();

        // 2 + 2 = 4
        beat(16'h0100, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 1'b0, 1'b0, 1'b1);
        expect_result("two_plus_two", 0);
        chk("two_plus_two_const_mag", 32'(out_mag), 32'h0200);
        chk("two_plus_two_const_cnt", 32'(out_count), 32'd2);

        // 1 + 1 + 2 = 4, back to back
        beat(16'h0000, 1'b0, 1'b0, 1'b0);
        beat(16'h0000, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 1'b0, 1'b0, 1'b1);
        expect_result("one_one_two", 0);
        chk("one_one_two_const_mag", 32'(out_mag), 32'h0200);
        chk("one_one_two_const_cnt", 32'(out_count), 32'd3);

        // exact cancellation
        beat(16'h0100, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 1'b1, 1'b0, 1'b1);
        expect_result("cancel", 0);
        chk("cancel_const_zero", 32'(out_zero), 32'd1);
        chk("cancel_const_mag",  32'(out_mag),  32'd0);
        chk("cancel_const_sign", 32'(out_sign), 32'd0);

        // zero then negative 4
        beat(16'hABCD, 1'b1, 1'b1, 1'b0);
        beat(16'h0200, 1'b1, 1'b0, 1'b1);
        expect_result("zero_neg", 0);
        chk("zero_neg_const_mag",  32'(out_mag),   32'h0200);
        chk("zero_neg_const_sign", 32'(out_sign),  32'd1);
        chk("zero_neg_const_cnt",  32'(out_count), 32'd1);

        // all-zero frame with non-zero garbage on ignored fields
        beat(16'h1234, 1'b1, 1'b1, 1'b0);
        beat(16'h0777, 1'b1, 1'b1, 1'b1);
        expect_result("all_zero", 0);
        chk("all_zero_const_zero", 32'(out_zero),  32'd1);
        chk("all_zero_const_mag",  32'(out_mag),   32'd0);
        chk("all_zero_const_sign", 32'(out_sign),  32'd0);
        chk("all_zero_const_cnt",  32'(out_count), 32'd0);

        // backpressure, then a fresh single-beat frame must not see the old sum
        beat(16'h0080, 1'b0, 1'b0, 1'b0);
        beat(16'hFF40, 1'b1, 1'b0, 1'b1);
        expect_result("stall", 5);
        beat(16'h0300, 1'b0, 1'b0, 1'b1);
        expect_result("after_stall", 0);
        chk("after_stall_const_mag", 32'(out_mag), 32'h0300);
        chk("after_stall_const_cnt", 32'(out_count), 32'd1);

        // reset mid-frame
        beat(16'h0100, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_mag",   32'(out_mag),   32'd0);
        chk("midrst_out_sign",  32'(out_sign),  32'd0);
        chk("midrst_out_zero",  32'(out_zero),  32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        model_new_frame();
        beat(16'h0200, 1'b0, 1'b0, 1'b1);
        expect_result("post_rst", 0);
        chk("post_rst_const_mag", 32'(out_mag), 32'h0200);
        chk("post_rst_const_cnt", 32'(out_count), 32'd1);

        // 300 terms of 1.0: count saturates
        for (int i = 0; i < 300; i++) begin
            beat(16'h0000, 1'b0, 1'b0, (i == 299));
        end
        expect_result("sat300", 2);
        chk("sat300_const_cnt", 32'(out_count), 32'd255);

        // randomized frames
        for (int f = 0; f < 30; f++) begin
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) tick();
                mg = 16'($urandom_range(0, 4095)) - 16'd2048;
                sg = 1'($urandom_range(0, 1));
                zr = ($urandom_range(0, 4) == 0);
                if (!m_first && !m_zero && $urandom_range(0, 3) == 0) begin
                    mg = m_mag;
                    sg = ~m_sign;
                    zr = 1'b0;
                end
                beat(mg, sg, zr, (k == nb - 1));
            end
            expect_result("rnd", $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
